// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store FSM in front of a word-indexed data memory (sub-word accesses enabled by LSU_SUBWORD_EN)
module load_store_unit #(
   parameter int AWIDTH  = 32,
   parameter int ALENGTH = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_uns,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [AWIDTH-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [AWIDTH-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [AWIDTH-1:0] mem_wdata,
   input  logic [AWIDTH-1:0] mem_rdata
);
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] RD   = 3'd1;
   localparam logic [2:0] WR   = 3'd3;
   localparam logic [2:0] RESP = 3'd4;
   localparam logic [AWIDTH-3:0] LEN = (AWIDTH-2)'(ALENGTH);
   logic [2:0]        state_q, state_d;
   logic              we_q, we_d, err_q, err_d;
   logic [AWIDTH-3:0] idx_q, idx_d;
   logic [AWIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [AWIDTH-1:0] ld_data;
   logic              size_bad, req_err;
`ifdef LSU_SUBWORD_EN
   localparam logic [2:0] RMW = 3'd2;
   logic [1:0]        size_q, size_d, off_q, off_d;
   logic              uns_q, uns_d;
   logic [4:0]        sh;
   logic [AWIDTH-1:0] lane, mask, merged;
   // lane alignment for sub-word loads and the read-modify-write merge
   always_comb begin
      sh      = {off_q, 3'b000};
      lane    = mem_rdata >> sh;
      mask    = size_q[0] ? (AWIDTH'(16'hFFFF) << sh) : (AWIDTH'(8'hFF) << sh);
      merged  = (mem_rdata & ~mask) | ((wdata_q << sh) & mask);
      ld_data = (size_q == 2'b00) ? {{(AWIDTH-8){~uns_q & lane[7]}}, lane[7:0]} :
                (size_q == 2'b01) ? {{(AWIDTH-16){~uns_q & lane[15]}}, lane[15:0]} : mem_rdata;
      size_bad = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
   end
`else
   logic unused_uns;
   assign unused_uns = req_uns;
   // only aligned word accesses are legal in this build
   always_comb begin
      ld_data  = mem_rdata;
      size_bad = (req_size != 2'b10) || (req_addr[1:0] != 2'b00);
   end
`endif
   assign req_err    = size_bad || (req_addr[AWIDTH-1:2] >= LEN) || (req_we && req_addr[AWIDTH-1:2] == '0);
   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign mem_we     = (state_q == WR);
   assign mem_wdata  = mem_we ? wdata_q : '0;
   assign mem_addr   = {2'b00, idx_q};
   // next state: latch request on acceptance, sequence memory phases, hold response until taken
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      err_d   = err_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef LSU_SUBWORD_EN
      size_d  = size_q;
      off_d   = off_q;
      uns_d   = uns_q;
`endif
      case (state_q)
         IDLE: if (req_valid) begin
            we_d    = req_we;
            err_d   = req_err;
            idx_d   = req_addr[AWIDTH-1:2];
            wdata_d = req_wdata;
            rdata_d = '0;
`ifdef LSU_SUBWORD_EN
            size_d  = req_size;
            off_d   = req_addr[1:0];
            uns_d   = req_uns;
            state_d = req_err ? RESP : !req_we ? RD : (req_size == 2'b10) ? WR : RMW;
`else
            state_d = req_err ? RESP : req_we ? WR : RD;
`endif
         end
         RD: begin
            rdata_d = ld_data;
            state_d = RESP;
         end
`ifdef LSU_SUBWORD_EN
         RMW: begin
            wdata_d = merged;
            state_d = WR;
         end
`endif
         WR:      state_d = RESP;
         RESP:    state_d = resp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   // state registers with asynchronous abort to idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef LSU_SUBWORD_EN
         size_q  <= 2'b00;
         off_q   <= 2'b00;
         uns_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
`ifdef LSU_SUBWORD_EN
         size_q  <= size_d;
         off_q   <= off_d;
         uns_q   <= uns_d;
`endif
      end
   end
   logic unused_we;
   assign unused_we = we_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized bench for load_store_unit against a byte-array memory model
module tb_load_store_unit;
   localparam int ALEN = 128;
   localparam int IW   = $clog2(ALEN);
   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0, resp_ready = 1'b0;
   logic [1:0]  req_size = 2'b10;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, resp_valid, resp_err, mem_we;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [31:0] mem [ALEN];
   logic [7:0]  ref_b [4*ALEN];
   logic        load_init = 1'b0;
   int          we_cnt = 0, bad_wd = 0, n_checks = 0, n_pass = 0;
   logic [31:0] last_we_addr = '0;

   load_store_unit #(.AWIDTH(32), .ALENGTH(ALEN)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

   always #5 clk = ~clk;

   assign mem_rdata = (mem_addr < 32'(ALEN)) ? mem[mem_addr[IW-1:0]] : 32'h0;

   // attached data memory, preloaded from the model's byte image
   always @(posedge clk) begin
      if (load_init)
         for (int i = 0; i < ALEN; i++) mem[i] <= {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
      else if (mem_we) begin
         mem[mem_addr[IW-1:0]] <= mem_wdata;
         we_cnt       <= we_cnt + 1;
         last_we_addr <= mem_addr;
      end
   end

   always @(negedge clk) if (!mem_we && mem_wdata != 0) bad_wd <= bad_wd + 1;

   function automatic logic [31:0] ref_word(input int idx);
      return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int hold);
      logic e;
      logic [31:0] rd;
      int lat, nb, n, w0, idx;
      nb  = 1 << size;
      idx = int'(addr >> 2);
      e = (size == 2'b11) || (addr % nb != 0) || (idx >= ALEN) || (we && idx == 0);
`ifndef LSU_SUBWORD_EN
      e = e || (size != 2'b10);
`endif
      lat = e ? 1 : (!we || size == 2'b10) ? 2 : 3;
      rd  = 32'h0;
      if (!e && !we) begin
         for (int i = 0; i < nb; i++) rd |= 32'(ref_b[int'(addr) + i]) << (8 * i);
         if (!uns && nb < 4 && rd[8*nb-1]) rd |= ~((32'd1 << (8 * nb)) - 32'd1);
      end
      if (!e && we) for (int i = 0; i < nb; i++) ref_b[int'(addr) + i] = wdata[8*i +: 8];
      @(negedge clk);
      check("req_ready_idle", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
      w0 = we_cnt;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 10);
      check("latency", 32'(n), 32'(lat));
      check("resp_err", {31'b0, resp_err}, {31'b0, e});
      check("resp_rdata", resp_rdata, rd);
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", {31'b0, resp_valid}, 32'd1);
         check("hold_rdata", resp_rdata, rd);
         check("hold_req_ready", {31'b0, req_ready}, 32'd0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      check("we_count", 32'(we_cnt - w0), (!e && we) ? 32'd1 : 32'd0);
      if (!e && we) begin
         check("we_addr", last_we_addr, 32'(idx));
         check("mem_word", mem[idx], ref_word(idx));
      end
   endtask

   initial begin
      logic [31:0] v, a, exp28;
      for (int i = 0; i < ALEN; i++) begin
         v = $urandom;
         for (int k = 0; k < 4; k++) ref_b[4*i+k] = v[8*k +: 8];
      end
      load_init = 1'b1;
      @(posedge clk);
      #1 load_init = 1'b0;
      @(negedge clk);
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_resp_err", {31'b0, resp_err}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_mem_we", {31'b0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
      check("mem4_word", mem[4], 32'hDEADBEEF);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
      do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
      do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
      do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0);
      do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h55, 0);
`ifdef LSU_SUBWORD_EN
      exp28 = 32'hDEAD55EF;
`else
      exp28 = 32'hDEADBEEF;
`endif
      check("mem4_byte_store", mem[4], exp28);
      do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h12345678, 0);
      do_req(1'b1, 2'b10, 1'b0, 32'h6, 32'h12345678, 0);
      do_req(1'b1, 2'b10, 1'b0, 32'(4 * ALEN), 32'h12345678, 0);
      do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 0);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);
      // abort a store while its write cycle is on the bus
      a = 32'h21;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_uns = 1'b0; req_addr = a; req_wdata = 32'hA5;
`ifdef LSU_SUBWORD_EN
      req_size = 2'b00;
`else
      req_size = 2'b10; a = 32'h20; req_addr = a;
`endif
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
`ifdef LSU_SUBWORD_EN
      @(negedge clk);
`endif
      check("wr_phase_we", {31'b0, mem_we}, 32'd1);
      rst = 1'b1;
      #1;
      check("abort_mem_we", {31'b0, mem_we}, 32'd0);
      check("abort_mem_wdata", mem_wdata, 32'd0);
      check("abort_mem_addr", mem_addr, 32'd0);
      check("abort_req_ready", {31'b0, req_ready}, 32'd1);
      check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("abort_resp_err", {31'b0, resp_err}, 32'd0);
      check("abort_resp_rdata", resp_rdata, 32'd0);
      @(posedge clk);
      #1 check("abort_mem_kept", mem[8], ref_word(8));
      @(negedge clk);
      rst = 1'b0;
      for (int t = 0; t < 150; t++) begin
         a = 32'($urandom_range(0, ALEN + 2)) * 4 + (($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'd0);
         do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
      end
      check("wdata_zero_idle", 32'(bad_wd), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
